mem_mp_prot: RTL and testbench

MEM_MP_PROT -- requirements
Module: mem_mp_prot

---
 rtl/mem_mp_pkg.sv | 23 ++
 rtl/mem_mp_region_chk.sv | 21 ++
 rtl/mem_mp_prot.sv | 139 +++++++++++++
 tb/tb_mem_mp_prot.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_mp_pkg.sv
// Shared types for the multi-port write-protected memory: region descriptor and FSM state.
package mem_mp_pkg;

  // Region bounds are stored at a fixed width so the struct stays parameter-free.
  localparam int REGION_AW = 32;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  typedef struct packed {
    logic                 en;
    logic [REGION_AW-1:0] start_addr;
    logic [REGION_AW-1:0] end_addr;
  } region_t;

  // Unsigned inclusive range test; start > end can never match.
  function automatic logic in_region(region_t rg, logic [REGION_AW-1:0] addr);
    return rg.en && (addr >= rg.start_addr) && (addr <= rg.end_addr);
  endfunction

endpackage

// File: rtl/mem_mp_region_chk.sv
// Write-protection lookup: flags an address covered by any enabled region.
module mem_mp_region_chk
  import mem_mp_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int NUM_REGION = 4
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  input  region_t               regions [NUM_REGION],
  output logic                  prot
);

  // NOTE: the output gets a default before the loop so no path leaves it unassigned (no latch).
  always_comb begin
    prot = 1'b0;
    for (int r = 0; r < NUM_REGION; r++) begin
      if (in_region(regions[r], REGION_AW'(addr))) prot = 1'b1;
    end
  end

endmodule

// File: rtl/mem_mp_prot.sv
// Multi-read-port memory with byte-enable writes, region write protection and a
// sequential clear engine. Optional macro MEM_MP_PROT_WR_BYPASS_EN forwards colliding writes to readers.
module mem_mp_prot
  import mem_mp_pkg::*;
#(
  parameter  int ADDR_WIDTH = 8,
  parameter  int DATA_WIDTH = 16,
  parameter  int NUM_RD     = 2,
  parameter  int NUM_REGION = 4,
  localparam int IDX_W      = (NUM_REGION > 1) ? $clog2(NUM_REGION) : 1
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic [NUM_RD-1:0]            rd_req,
  input  logic [NUM_RD*ADDR_WIDTH-1:0] rd_addr,
  output logic [NUM_RD-1:0]            rd_ack,
  output logic [NUM_RD*DATA_WIDTH-1:0] rd_data,
  input  logic                         wr_req,
  input  logic [ADDR_WIDTH-1:0]        wr_addr,
  input  logic [DATA_WIDTH-1:0]        wr_data,
  input  logic [DATA_WIDTH/8-1:0]      wr_be,
  output logic                         wr_ack,
  output logic                         wr_err,
  input  logic                         perm_req,
  input  logic [IDX_W-1:0]             perm_idx,
  input  logic                         perm_en,
  input  logic [ADDR_WIDTH-1:0]        perm_start,
  input  logic [ADDR_WIDTH-1:0]        perm_end,
  output logic                         perm_ack,
  input  logic                         clr_req,
  output logic                         busy
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int NB    = DATA_WIDTH / 8;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   clr_cnt;
  region_t                 regions [NUM_REGION];
  logic [DATA_WIDTH-1:0]   mem     [DEPTH];
  logic [DATA_WIDTH-1:0]   rd_word [NUM_RD];
  logic [DATA_WIDTH-1:0]   wr_mask;
  logic                    idle;
  logic                    wr_prot;
  logic                    wr_go;

  mem_mp_region_chk #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .NUM_REGION (NUM_REGION)
  ) u_region_chk (
    .addr    (wr_addr),
    .regions (regions),
    .prot    (wr_prot)
  );

  assign idle  = (state == IDLE);
  assign busy  = (state == CLEAR);
  assign wr_go = rstn & idle & wr_req & ~wr_prot;

  always_comb begin
    wr_mask = '0;
    for (int b = 0; b < NB; b++) wr_mask[b*8 +: 8] = {8{wr_be[b]}};
  end

  // Read-first by default: the array value is the one before this cycle's write.
  always_comb begin
    for (int i = 0; i < NUM_RD; i++) begin
      rd_word[i] = mem[rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH]];
`ifdef MEM_MP_PROT_WR_BYPASS_EN
      if (wr_go && (rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH] == wr_addr))
        rd_word[i] = (rd_word[i] & ~wr_mask) | (wr_data & wr_mask);
`endif
    end
  end

  // NOTE: the array has no reset; zeroing it is the job of the CLEAR sequence,
  // which keeps it mappable onto RAM primitives.
  always_ff @(posedge clk) begin
    if (state == CLEAR) begin
      mem[clr_cnt] <= '0;
    end else if (wr_go) begin
      mem[wr_addr] <= (mem[wr_addr] & ~wr_mask) | (wr_data & wr_mask);
    end
  end

  // NOTE: all state is updated with non-blocking assignments so every read in
  // this block sees the pre-edge value, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state    <= CLEAR;
      clr_cnt  <= '0;
      rd_ack   <= '0;
      rd_data  <= '0;
      wr_ack   <= 1'b0;
      wr_err   <= 1'b0;
      perm_ack <= 1'b0;
      for (int r = 0; r < NUM_REGION; r++) regions[r] <= '0;
      regions[0].en <= 1'b1;
    end else begin
      rd_ack   <= '0;
      wr_ack   <= 1'b0;
      wr_err   <= 1'b0;
      perm_ack <= 1'b0;
      case (state)
        CLEAR: begin
          clr_cnt <= clr_cnt + 1'b1;
          if (clr_cnt == {ADDR_WIDTH{1'b1}}) state <= IDLE;
        end
        default: begin
          if (clr_req) begin
            state   <= CLEAR;
            clr_cnt <= '0;
          end
          for (int i = 0; i < NUM_RD; i++) begin
            if (rd_req[i]) begin
              rd_ack[i]                      <= 1'b1;
              rd_data[i*DATA_WIDTH +: DATA_WIDTH] <= rd_word[i];
            end
          end
          if (wr_req) begin
            wr_ack <= 1'b1;
            wr_err <= wr_prot;
          end
          // Out-of-range indices match no region and are acked without effect.
          if (perm_req) begin
            perm_ack <= 1'b1;
            for (int r = 0; r < NUM_REGION; r++) begin
              if (perm_idx == IDX_W'(r))
                regions[r] <= '{en: perm_en,
                                start_addr: REGION_AW'(perm_start),
                                end_addr: REGION_AW'(perm_end)};
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_mp_prot.sv
// Self-checking bench for mem_mp_prot: directed scenarios plus a randomized mix
// checked against an array-based model of memory contents and protection regions.
module tb_mem_mp_prot;

  localparam int AW   = 8;
  localparam int DW   = 16;
  localparam int NRD  = 2;
  localparam int NREG = 4;
  localparam int IW   = 2;
  localparam int NB   = DW / 8;
  localparam int WAIT_MAX = 600;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic [NRD-1:0]    rd_req = '0;
  logic [NRD*AW-1:0] rd_addr = '0;
  logic [NRD-1:0]    rd_ack;
  logic [NRD*DW-1:0] rd_data;
  logic              wr_req = 1'b0;
  logic [AW-1:0]     wr_addr = '0;
  logic [DW-1:0]     wr_data = '0;
  logic [NB-1:0]     wr_be = '0;
  logic              wr_ack, wr_err;
  logic              perm_req = 1'b0;
  logic [IW-1:0]     perm_idx = '0;
  logic              perm_en = 1'b0;
  logic [AW-1:0]     perm_start = '0, perm_end = '0;
  logic              perm_ack;
  logic              clr_req = 1'b0;
  logic              busy;

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] model_mem [2**AW];
  bit            m_en    [NREG];
  int            m_start [NREG];
  int            m_end   [NREG];

  mem_mp_prot dut (
    .clk(clk), .rstn(rstn),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack), .rd_data(rd_data),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
    .wr_ack(wr_ack), .wr_err(wr_err),
    .perm_req(perm_req), .perm_idx(perm_idx), .perm_en(perm_en),
    .perm_start(perm_start), .perm_end(perm_end), .perm_ack(perm_ack),
    .clr_req(clr_req), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic bit model_prot(int a);
    for (int r = 0; r < NREG; r++)
      if (m_en[r] && a >= m_start[r] && a <= m_end[r]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [DW-1:0] merge(logic [DW-1:0] old_w, logic [DW-1:0] new_w,
                                          logic [NB-1:0] be);
    logic [DW-1:0] res = old_w;
    for (int b = 0; b < NB; b++) if (be[b]) res[b*8 +: 8] = new_w[b*8 +: 8];
    return res;
  endfunction

  task automatic model_after_clear();
    for (int a = 0; a < 2**AW; a++) model_mem[a] = '0;
  endtask

  task automatic model_after_reset();
    model_after_clear();
    for (int r = 0; r < NREG; r++) begin
      m_en[r] = 1'b0; m_start[r] = 0; m_end[r] = 0;
    end
    m_en[0] = 1'b1;
  endtask

  // All transaction tasks start and end right after a falling edge.
  task automatic write_op(input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input logic [NB-1:0] be, input string name);
    bit exp_err = model_prot(int'(a));
    int n = 0;
    wr_req = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
    do begin @(negedge clk); n++; end while (!wr_ack && n < WAIT_MAX);
    wr_req = 1'b0;
    checks++;
    if (wr_ack !== 1'b1) begin
      errors++;
      $display("FAIL %s wr_ack: got %b want 1 (addr %h)", name, wr_ack, a);
    end
    checks++;
    if (wr_err !== exp_err) begin
      errors++;
      $display("FAIL %s wr_err: got %b want %b (addr %h)", name, wr_err, exp_err, a);
    end
    if (!exp_err) model_mem[a] = merge(model_mem[a], d, be);
  endtask

  task automatic read_op(input int p, input logic [AW-1:0] a, input string name);
    logic [DW-1:0] exp_d = model_mem[a];
    int n = 0;
    rd_req[p] = 1'b1; rd_addr[p*AW +: AW] = a;
    do begin @(negedge clk); n++; end while (!rd_ack[p] && n < WAIT_MAX);
    rd_req[p] = 1'b0;
    checks++;
    if (rd_ack[p] !== 1'b1 || rd_data[p*DW +: DW] !== exp_d) begin
      errors++;
      $display("FAIL %s port%0d addr %h: got ack=%b data=%h want ack=1 data=%h",
               name, p, a, rd_ack[p], rd_data[p*DW +: DW], exp_d);
    end
  endtask

  task automatic perm_op(input int idx, input bit en, input int s, input int e,
                         input string name);
    int n = 0;
    perm_req = 1'b1; perm_idx = IW'(idx); perm_en = en;
    perm_start = AW'(s); perm_end = AW'(e);
    do begin @(negedge clk); n++; end while (!perm_ack && n < WAIT_MAX);
    perm_req = 1'b0;
    checks++;
    if (perm_ack !== 1'b1) begin
      errors++;
      $display("FAIL %s perm_ack: got %b want 1", name, perm_ack);
    end
    if (idx < NREG) begin
      m_en[idx] = en; m_start[idx] = s; m_end[idx] = e;
    end
  endtask

  task automatic count_busy(input string name);
    int n = 0;
    while (busy && n < 1000) begin @(negedge clk); n++; end
    checks++;
    if (n != 2**AW) begin
      errors++;
      $display("FAIL %s busy length: got %0d want %0d cycles", name, n, 2**AW);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b1 || {rd_ack, wr_ack, wr_err, perm_ack, rd_data} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: busy=%b acks=%b/%b/%b err=%b rd_data=%h want busy=1 rest 0",
               busy, rd_ack, wr_ack, perm_ack, wr_err, rd_data);
    end
    rstn = 1'b1;
    repeat (100) @(negedge clk);
    // Re-entering reset mid-clear must restart the sweep from address 0.
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    model_after_reset();
    count_busy("reset_clear");
    for (int k = 0; k < 4; k++)
      read_op($urandom_range(0, NRD-1), AW'($urandom_range(0, 2**AW-1)), "reset_read");
    read_op(0, 8'hFF, "reset_read_last");
  endtask

  task automatic test_addr0_protect();
    write_op(8'h00, 16'h1234, 2'b11, "addr0_write");
    read_op(1, 8'h00, "addr0_read");
  endtask

  task automatic test_region();
    perm_op(1, 1'b1, 'h10, 'h1F, "region1_prog");
    write_op(8'h1F, 16'hBEEF, 2'b11, "region_edge_write");
    read_op(0, 8'h1F, "region_edge_read");
    write_op(8'h20, 16'hBEEF, 2'b11, "region_out_write");
    read_op(1, 8'h20, "region_out_read");
  endtask

  task automatic test_perm_same_cycle();
    logic exp_err0;
    exp_err0 = model_prot('h85);
    perm_req = 1'b1; perm_idx = 2'd2; perm_en = 1'b1; perm_start = 8'h80; perm_end = 8'h8F;
    wr_req = 1'b1; wr_addr = 8'h85; wr_data = 16'h0A0B; wr_be = 2'b11;
    @(negedge clk);
    perm_req = 1'b0; wr_req = 1'b0;
    checks++;
    if (perm_ack !== 1'b1 || wr_ack !== 1'b1 || wr_err !== exp_err0) begin
      errors++;
      $display("FAIL perm_same_cycle: perm_ack=%b wr_ack=%b wr_err=%b want 1 1 %b",
               perm_ack, wr_ack, wr_err, exp_err0);
    end
    if (!exp_err0) model_mem['h85] = 16'h0A0B;
    m_en[2] = 1'b1; m_start[2] = 'h80; m_end[2] = 'h8F;
    write_op(8'h85, 16'hFFFF, 2'b11, "perm_next_write");
    read_op(0, 8'h85, "perm_next_read");
  endtask

  task automatic test_byte_enable();
    write_op(8'h40, 16'hAAAA, 2'b11, "be_full");
    write_op(8'h40, 16'h5500, 2'b10, "be_upper");
    read_op(0, 8'h40, "be_read");
  endtask

  task automatic test_collision();
    logic [DW-1:0] old_w, exp_d;
    old_w = model_mem['h40];
`ifdef MEM_MP_PROT_WR_BYPASS_EN
    exp_d = 16'h1111;
`else
    exp_d = old_w;
`endif
    rd_req = '1; rd_addr = {8'h40, 8'h40};
    wr_req = 1'b1; wr_addr = 8'h40; wr_data = 16'h1111; wr_be = 2'b11;
    @(negedge clk);
    rd_req = '0; wr_req = 1'b0;
    for (int p = 0; p < NRD; p++) begin
      checks++;
      if (rd_ack[p] !== 1'b1 || rd_data[p*DW +: DW] !== exp_d) begin
        errors++;
        $display("FAIL collision port%0d: ack=%b data=%h want ack=1 data=%h",
                 p, rd_ack[p], rd_data[p*DW +: DW], exp_d);
      end
    end
    checks++;
    if (wr_ack !== 1'b1 || wr_err !== 1'b0) begin
      errors++;
      $display("FAIL collision_write: ack=%b err=%b want 1 0", wr_ack, wr_err);
    end
    model_mem['h40] = 16'h1111;
    read_op(1, 8'h40, "collision_after");
  endtask

  task automatic test_clear_mid();
    int n = 0, busy_n = 0;
    bit acked = 1'b0, ack_busy = 1'b0;
    clr_req = 1'b1;
    @(negedge clk);
    clr_req = 1'b0;
    while (n < 1000 && !acked) begin
      if (busy) busy_n++;
      if (wr_ack) begin
        acked = 1'b1;
        ack_busy = busy;
        wr_req = 1'b0;
      end else begin
        if (n == 50) begin
          wr_req = 1'b1; wr_addr = 8'h30; wr_data = 16'h7777; wr_be = 2'b11;
        end
        clr_req = (n == 100);
        @(negedge clk);
        n++;
      end
    end
    wr_req = 1'b0; clr_req = 1'b0;
    checks++;
    if (!acked || ack_busy || busy_n != 2**AW) begin
      errors++;
      $display("FAIL clear_mid: acked=%b ack_while_busy=%b busy_cycles=%0d want 1 0 %0d",
               acked, ack_busy, busy_n, 2**AW);
    end
    checks++;
    if (wr_err !== 1'b0) begin
      errors++;
      $display("FAIL clear_mid_err: got %b want 0", wr_err);
    end
    model_after_clear();
    model_mem['h30] = 16'h7777;
    read_op(0, 8'h30, "clear_write_landed");
    read_op(1, 8'h40, "clear_zeroed");
  endtask

  task automatic test_random();
    for (int k = 0; k < 200; k++) begin
      case ($urandom_range(0, 3))
        0, 1: write_op(AW'($urandom_range(0, 63)), DW'($urandom),
                       NB'($urandom_range(0, 2**NB-1)), "rand_write");
        2: perm_op($urandom_range(0, NREG-1), bit'($urandom_range(0, 1)),
                   $urandom_range(0, 63), $urandom_range(0, 63), "rand_perm");
        default: read_op($urandom_range(0, NRD-1), AW'($urandom_range(0, 63)), "rand_read");
      endcase
    end
    for (int a = 0; a < 64; a += 7) read_op(a % NRD, AW'(a), "rand_sweep");
  endtask

  initial begin
    test_reset();
    test_addr0_protect();
    test_region();
    test_perm_same_cycle();
    test_byte_enable();
    test_collision();
    test_clear_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
